enemy_shot_move: RTL and testbench
==================================

ENEMY_SHOT_MOVE -- requirements
Module: enemy_shot_move

Interface
REQ-001 SHALL have parameters: FIXED_POINT_MULTIPLIER, default 64, pixel-to-fixed-point scale.
REQ-002 SHALL have DOWN_SPEED, default 100, fixed-point Y step per frame for straight shots.
REQ-003 SHALL have LATERAL_SPEED, default 30, fixed-point X step magnitude for angled shots.
REQ-004 SHALL have ANGLED_DOWN_SPEED, default 70, fixed-point Y step for angled shots.
REQ-005 SHALL have COOLDOWN_FRAMES, default 60, frames between shot end and next fire acceptance.
REQ-006 SHALL have Y_MAX_FP, default 30080, fixed-point bottom limit; X_MIN_FP, default 40; X_MAX_FP, default 40900; PARK_FP, default 50000, off-screen park coordinate for X and Y.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-008 SHALL have: startOfFrame  in  1  one-cycle pulse per frame.
REQ-009 SHALL have: fireRequest  in  1  one-cycle fire pulse from enemy logic.
REQ-010 SHALL have: enemy_topLeftX, enemy_topLeftY  in  11 signed each  enemy pixel position.
REQ-011 SHALL have: shotDirection  in  3  001 right-down, 010 straight down, 100 left-down.
REQ-012 SHALL have: shotPlayerCollision  in  1  shot overlaps player; shotBoxCollision  in  1  shot overlaps obstacle.
REQ-013 SHALL have: pause  in  1  freeze motion and cooldown.
REQ-014 SHALL have outputs: ready  out  1  IDLE and able to fire; topLeftX, topLeftY  out  11 signed  shot pixel position; draw_shot_dir  out  3  latched direction, 0 when inactive; playerHit  out  1  one-cycle hit pulse.

Function
REQ-015 SHALL implement states IDLE, FLYING, COOLDOWN; ready SHALL equal (state==IDLE).
REQ-016 SHALL, in IDLE with fireRequest=1 and pause=0, load X/Y fixed = enemy_topLeft*FIXED_POINT_MULTIPLIER, load speeds, latch draw_shot_dir, enter FLYING next cycle.
REQ-017 SHALL map direction: 001 -> X=+LATERAL_SPEED, Y=+ANGLED_DOWN_SPEED; 100 -> X=-LATERAL_SPEED, Y=+ANGLED_DOWN_SPEED; 010 and all other codes -> X=0, Y=+DOWN_SPEED, draw_shot_dir=010.
REQ-018 SHALL ignore fireRequest outside IDLE or while pause=1; no request queuing.
REQ-019 SHALL, in FLYING on startOfFrame with pause=0, add Xspeed and Yspeed (Y increases downward) to fixed-point position.
REQ-020 SHALL, if next Y > Y_MAX_FP, or next X < X_MIN_FP, or next X > X_MAX_FP, instead park (X=Y=PARK_FP), zero speeds, draw_shot_dir=0, load cooldown counter, enter COOLDOWN.
REQ-021 SHALL, in FLYING with shotPlayerCollision=1, assert playerHit for exactly one cycle, park, and enter COOLDOWN, regardless of pause.
REQ-022 SHALL, in FLYING with shotBoxCollision=1 (no player collision), park and enter COOLDOWN without playerHit.
REQ-023 SHALL give collision priority over same-cycle startOfFrame motion; both collisions same cycle -> playerHit asserted once.
REQ-024 SHALL ignore collision inputs outside FLYING; a collision held high for many cycles SHALL yield one playerHit.
REQ-025 SHALL, in COOLDOWN, decrement the counter on each startOfFrame with pause=0, and enter IDLE the cycle after counter reaches 0; COOLDOWN_FRAMES=0 SHALL return to IDLE next cycle.
REQ-026 SHALL hold position, speeds and cooldown counter unchanged while pause=1.
REQ-027 SHALL compute topLeftX/Y = fixed position divided by FIXED_POINT_MULTIPLIER (floor, arithmetic shift); position registers SHALL be at least 17 bits signed.

Reset
REQ-028 SHALL on reset=1 at a clock edge: state IDLE, X=Y=PARK_FP (topLeft=781,781), speeds 0, counter 0, draw_shot_dir=0, playerHit=0, ready=1; reset SHALL override all inputs, including mid-flight.

Verification
REQ-029 Enemy (100,50), dir 010, fire -> next cycle ready=0, topLeft=(100,50); after 1 frame Y=51; after 268 frames still flying, frame 269 -> parked (781,781), COOLDOWN.
REQ-030 Enemy (630,10), dir 001, fire -> X fixed 40320; frames 1-19 advance X by 30; frame 20 -> parked, draw_shot_dir=0.
REQ-031 FLYING, shotPlayerCollision high 5 cycles coinciding with startOfFrame -> single 1-cycle playerHit, no motion that cycle, parked.
REQ-032 After shot end, fireRequest each frame -> ignored for 60 frames; ready=1 after 60th startOfFrame; next fireRequest accepted.
REQ-033 Pause=1 during FLYING for 10 frames -> position constant; fireRequest during IDLE with pause=1 -> ignored.
REQ-034 Reset asserted mid-flight with collision high -> next cycle IDLE, (781,781), playerHit=0, ready=1.

Source files
------------

// File: rtl/enemy_shot_move.sv
// Enemy shot mover: a single projectile that is launched from the enemy
// position, advances once per frame in fixed-point, and is parked off-screen
// when it leaves the playfield or hits something.  After the shot ends a
// frame-counted cooldown blocks the next launch.
//
// Fire handshake: fireRequest is a one-cycle request, accepted only on a cycle
// where ready=1 and pause=0.  A request on any other cycle is dropped (there
// is no queue); the enemy logic must re-request once ready returns high.
module enemy_shot_move #(
  parameter int FIXED_POINT_MULTIPLIER = 64,
  parameter int DOWN_SPEED             = 100,
  parameter int LATERAL_SPEED          = 30,
  parameter int ANGLED_DOWN_SPEED      = 70,
  parameter int COOLDOWN_FRAMES        = 60,
  parameter int Y_MAX_FP               = 30080,
  parameter int X_MIN_FP               = 40,
  parameter int X_MAX_FP               = 40900,
  parameter int PARK_FP                = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               fireRequest,
  input  logic signed [10:0] enemy_topLeftX,
  input  logic signed [10:0] enemy_topLeftY,
  input  logic [2:0]         shotDirection,
  input  logic               shotPlayerCollision,
  input  logic               shotBoxCollision,
  input  logic               pause,
  output logic               ready,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [2:0]         draw_shot_dir,
  output logic               playerHit,
  output logic [1:0]         dbg_state
);

  // Position width: 11-bit pixel times the multiplier plus headroom for one
  // step past the edges, so the bounds compare never wraps.
  localparam int POS_W = 24;
  localparam int CNT_W = 16;
  localparam int SHIFT = $clog2(FIXED_POINT_MULTIPLIER);

  localparam logic signed [POS_W-1:0] MULT_S  = POS_W'(FIXED_POINT_MULTIPLIER);
  localparam logic signed [POS_W-1:0] DOWN_S  = POS_W'(DOWN_SPEED);
  localparam logic signed [POS_W-1:0] LAT_S   = POS_W'(LATERAL_SPEED);
  localparam logic signed [POS_W-1:0] ANG_S   = POS_W'(ANGLED_DOWN_SPEED);
  localparam logic signed [POS_W-1:0] Y_MAX_S = POS_W'(Y_MAX_FP);
  localparam logic signed [POS_W-1:0] X_MIN_S = POS_W'(X_MIN_FP);
  localparam logic signed [POS_W-1:0] X_MAX_S = POS_W'(X_MAX_FP);
  localparam logic signed [POS_W-1:0] PARK_S  = POS_W'(PARK_FP);
  localparam logic [CNT_W-1:0]        COOL_C  = CNT_W'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLYING   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t                   state, state_n;
  logic signed [POS_W-1:0]  x_fp, y_fp, x_n, y_n;
  logic signed [POS_W-1:0]  vx, vy, vx_n, vy_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [2:0]               dir_n;
  logic                     hit_n;
  logic                     do_park;

  logic signed [POS_W-1:0]  ex_ext, ey_ext;
  logic signed [POS_W-1:0]  x_step, y_step;
  logic                     out_of_bounds;

  assign ex_ext = POS_W'(enemy_topLeftX);
  assign ey_ext = POS_W'(enemy_topLeftY);

  // Candidate position for this frame; the bounds test is made on it so the
  // shot never becomes visible outside the playfield.
  assign x_step        = x_fp + vx;
  assign y_step        = y_fp + vy;
  assign out_of_bounds = (y_step > Y_MAX_S) || (x_step < X_MIN_S) || (x_step > X_MAX_S);

  // Next-state and datapath: launch, per-frame motion, collision/park, cooldown.
  always_comb begin
    state_n = state;
    x_n     = x_fp;
    y_n     = y_fp;
    vx_n    = vx;
    vy_n    = vy;
    cnt_n   = cnt;
    dir_n   = draw_shot_dir;
    hit_n   = 1'b0;
    do_park = 1'b0;

    case (state)
      S_IDLE: begin
        if (fireRequest && !pause) begin
          x_n     = ex_ext * MULT_S;
          y_n     = ey_ext * MULT_S;
          state_n = S_FLYING;
          case (shotDirection)
            3'b001: begin
              vx_n  = LAT_S;
              vy_n  = ANG_S;
              dir_n = 3'b001;
            end
            3'b100: begin
              vx_n  = -LAT_S;
              vy_n  = ANG_S;
              dir_n = 3'b100;
            end
            default: begin
              // Unknown codes fall back to a straight shot.
              vx_n  = '0;
              vy_n  = DOWN_S;
              dir_n = 3'b010;
            end
          endcase
        end
      end

      S_FLYING: begin
        // Collisions win over motion and are honoured even while paused.
        if (shotPlayerCollision) begin
          hit_n   = 1'b1;
          do_park = 1'b1;
        end else if (shotBoxCollision) begin
          do_park = 1'b1;
        end else if (startOfFrame && !pause) begin
          if (out_of_bounds) begin
            do_park = 1'b1;
          end else begin
            x_n = x_step;
            y_n = y_step;
          end
        end
      end

      S_COOLDOWN: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
        end else if (startOfFrame && !pause) begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (do_park) begin
      x_n     = PARK_S;
      y_n     = PARK_S;
      vx_n    = '0;
      vy_n    = '0;
      dir_n   = 3'b000;
      cnt_n   = COOL_C;
      state_n = S_COOLDOWN;
    end
  end

  // State and datapath registers; reset parks the shot and overrides all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      x_fp          <= PARK_S;
      y_fp          <= PARK_S;
      vx            <= '0;
      vy            <= '0;
      cnt           <= '0;
      draw_shot_dir <= 3'b000;
      playerHit     <= 1'b0;
    end else begin
      state         <= state_n;
      x_fp          <= x_n;
      y_fp          <= y_n;
      vx            <= vx_n;
      vy            <= vy_n;
      cnt           <= cnt_n;
      draw_shot_dir <= dir_n;
      playerHit     <= hit_n;
    end
  end

  // Pixel position is the floor of fixed-point / multiplier (arithmetic shift).
  assign topLeftX  = 11'(x_fp >>> SHIFT);
  assign topLeftY  = 11'(y_fp >>> SHIFT);
  assign ready     = (state == S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_enemy_shot_move.sv
// Bench for enemy_shot_move: directed scenarios with literal expectations,
// then a long randomized run, all checked against an integer-level model.
module tb_enemy_shot_move;

  localparam int MULT  = 64;
  localparam int DOWN  = 100;
  localparam int LAT   = 30;
  localparam int ANG   = 70;
  localparam int COOL  = 60;
  localparam int Y_MAX = 30080;
  localparam int X_MIN = 40;
  localparam int X_MAX = 40900;
  localparam int PARK  = 50000;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startOfFrame = 1'b0, fireRequest = 1'b0, pause = 1'b0;
  logic shotPlayerCollision = 1'b0, shotBoxCollision = 1'b0;
  logic signed [10:0] enemy_topLeftX = '0, enemy_topLeftY = '0;
  logic [2:0] shotDirection = 3'b010;
  logic ready, playerHit;
  logic signed [10:0] topLeftX, topLeftY;
  logic [2:0] draw_shot_dir;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  enemy_shot_move dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .fireRequest(fireRequest),
    .enemy_topLeftX(enemy_topLeftX), .enemy_topLeftY(enemy_topLeftY),
    .shotDirection(shotDirection), .shotPlayerCollision(shotPlayerCollision),
    .shotBoxCollision(shotBoxCollision), .pause(pause), .ready(ready),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .draw_shot_dir(draw_shot_dir),
    .playerHit(playerHit), .dbg_state(dbg_state)
  );

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_FLY, P_COOL} phase_t;
  phase_t m_phase = P_IDLE;
  int mx = PARK, my = PARK, mvx = 0, mvy = 0, m_cool = 0, m_dir = 0;
  bit m_hit = 1'b0;

  function automatic int floor_div(int v, int d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  task automatic m_park();
    mx = PARK; my = PARK; mvx = 0; mvy = 0; m_dir = 0;
    m_cool = COOL; m_phase = P_COOL;
  endtask

  task automatic model_step();
    int nx, ny;
    m_hit = 1'b0;
    if (reset) begin
      m_phase = P_IDLE; mx = PARK; my = PARK; mvx = 0; mvy = 0; m_cool = 0; m_dir = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (fireRequest && !pause) begin
          mx = int'(enemy_topLeftX) * MULT;
          my = int'(enemy_topLeftY) * MULT;
          if (shotDirection == 3'b001)      begin mvx =  LAT; mvy = ANG;  m_dir = 1; end
          else if (shotDirection == 3'b100) begin mvx = -LAT; mvy = ANG;  m_dir = 4; end
          else                              begin mvx = 0;    mvy = DOWN; m_dir = 2; end
          m_phase = P_FLY;
        end
        P_FLY: begin
          if (shotPlayerCollision || shotBoxCollision) begin
            m_hit = shotPlayerCollision;
            m_park();
          end else if (startOfFrame && !pause) begin
            nx = mx + mvx;
            ny = my + mvy;
            if (ny > Y_MAX || nx < X_MIN || nx > X_MAX) m_park();
            else begin mx = nx; my = ny; end
          end
        end
        P_COOL: begin
          if (m_cool == 0) m_phase = P_IDLE;
          else if (startOfFrame && !pause) m_cool--;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // Advance the model on every edge and compare all outputs just after it.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("m_ready", ready, (m_phase == P_IDLE));
    chk("m_x", topLeftX, floor_div(mx, MULT));
    chk("m_y", topLeftY, floor_div(my, MULT));
    chk("m_dir", draw_shot_dir, m_dir);
    chk("m_hit", playerHit, m_hit);
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge: apply inputs, let one rising edge consume them,
  // return at the following falling edge with outputs settled.
  task automatic step(input bit rst, input bit sof, input bit fire,
                      input bit pc, input bit bc, input bit pz);
    reset = rst; startOfFrame = sof; fireRequest = fire;
    shotPlayerCollision = pc; shotBoxCollision = bc; pause = pz;
    @(negedge clk);
  endtask

  task automatic frame(input bit pz);
    step(0, 1, 0, 0, 0, pz);
    step(0, 0, 0, 0, 0, pz);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic launch(input int px, input int py, input logic [2:0] d);
    enemy_topLeftX = 11'(px); enemy_topLeftY = 11'(py); shotDirection = d;
    step(0, 0, 1, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hits;
    @(negedge clk);
    do_reset();
    chk("rst_ready", ready, 1);
    chk("rst_x", topLeftX, 781);
    chk("rst_y", topLeftY, 781);
    chk("rst_dir", draw_shot_dir, 0);

    // Straight shot to the bottom edge, then the cooldown with ignored fires.
    launch(100, 50, 3'b010);
    chk("s_ready", ready, 0);
    chk("s_x0", topLeftX, 100);
    chk("s_y0", topLeftY, 50);
    frame(0);
    chk("s_y1", topLeftY, 51);
    for (int i = 0; i < 267; i++) frame(0);
    chk("s_y268", topLeftY, 468);
    chk("s_dir268", draw_shot_dir, 2);
    frame(0);
    chk("s_park_x", topLeftX, 781);
    chk("s_park_y", topLeftY, 781);
    chk("s_park_dir", draw_shot_dir, 0);
    chk("s_park_ready", ready, 0);
    for (int i = 0; i < 60; i++) begin
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      if (i == 58) chk("cool_59_ready", ready, 0);
    end
    chk("cool_60_ready", ready, 1);
    launch(200, 100, 3'b010);
    chk("cool_refire", ready, 0);
    chk("cool_refire_x", topLeftX, 200);

    // Right-down shot leaving through the right edge.
    do_reset();
    launch(630, 10, 3'b001);
    chk("r_x0", topLeftX, 630);
    chk("r_dir", draw_shot_dir, 1);
    for (int i = 0; i < 19; i++) frame(0);
    chk("r_x19", topLeftX, 638);
    chk("r_y19", topLeftY, 30);
    frame(0);
    chk("r_park_x", topLeftX, 781);
    chk("r_park_dir", draw_shot_dir, 0);

    // Held player collision coinciding with frame pulses: one hit, no motion.
    do_reset();
    launch(100, 50, 3'b100);
    frame(0);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1, 1, 0);
      if (i == 0) begin
        chk("hit_first", playerHit, 1);
        chk("hit_park_y", topLeftY, 781);
      end
      hits += int'(playerHit);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("hit_once", hits, 1);

    // Pause freezes flight; fire while paused in IDLE is dropped.
    do_reset();
    launch(100, 50, 3'b010);
    frame(0);
    for (int i = 0; i < 10; i++) frame(1);
    chk("pause_y", topLeftY, 51);
    chk("pause_x", topLeftX, 100);
    frame(0);
    chk("unpause_y", topLeftY, 53);
    do_reset();
    step(0, 0, 1, 0, 0, 1);
    chk("pause_fire_ready", ready, 1);
    chk("pause_fire_x", topLeftX, 781);

    // Reset mid-flight with a collision present.
    launch(300, 200, 3'b001);
    frame(0);
    step(1, 1, 0, 1, 0, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_x", topLeftX, 781);
    chk("midrst_y", topLeftY, 781);
    chk("midrst_hit", playerHit, 0);
    step(0, 0, 0, 0, 0, 0);

    // Randomized run.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        enemy_topLeftX = 11'($urandom_range(0, 700));
        enemy_topLeftY = 11'($urandom_range(0, 470));
      end else begin
        enemy_topLeftX = 11'($urandom);
        enemy_topLeftY = 11'($urandom);
      end
      shotDirection = 3'($urandom);
      step($urandom_range(0, 999) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
